event_uart_packetizer: RTL

//   Host/sensor-side transmitter for the 5-byte UART event protocol consumed by the gesture core.

---
 rtl/event_uart_packetizer.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/event_uart_packetizer.sv
// DVS event transmitter: buffers {x,y,pol,ts} events in a small FIFO and serialises each one
// as five 8N1 UART bytes (x, y, {pol,ts[22:16]}, ts[15:8], ts[7:0]), each byte LSB first.
module event_uart_packetizer #(
    parameter int CLK_FREQ_HZ  = 12_000_000,
    parameter int BAUD_RATE    = 115200,
    parameter int FIFO_DEPTH   = 4,
    parameter int PKT_GAP_BITS = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [7:0]                  evt_x,
    input  logic [7:0]                  evt_y,
    input  logic                        evt_pol,
    input  logic [22:0]                 evt_ts,
    input  logic                        evt_valid,
    output logic                        evt_ready,
    output logic                        uart_tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    localparam int BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int PTR_W        = $clog2(FIFO_DEPTH);
    localparam int CNT_W        = PTR_W + 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]        GAP_LAST  = 4'(PKT_GAP_BITS - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_DATA, S_STOP, S_GAP} state_t;

    logic [39:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    state_t            r_state;
    state_t            w_state_next;
    logic [BAUD_W-1:0] r_baud;
    logic [BAUD_W-1:0] w_baud_next;
    logic [3:0]        r_bit_idx;
    logic [3:0]        w_bit_idx_next;
    logic [2:0]        r_byte_idx;
    logic [2:0]        w_byte_idx_next;
    logic [39:0]       r_pkt;
    logic [39:0]       w_pkt_next;
    logic [39:0]       w_head;
    logic              r_tx;
    logic              w_tx_next;
    logic              r_busy;
    logic              w_busy_next;
    logic              w_push;
    logic              w_pop;
    logic              w_bit_end;

    assign evt_ready  = !rst && (r_count != CNT_FULL);
    assign w_push     = evt_valid && evt_ready;
    assign w_bit_end  = (r_baud == BAUD_LAST);
    assign w_head     = r_mem[r_rd_ptr];
    assign uart_tx    = r_tx;
    assign busy       = r_busy;
    assign fifo_count = r_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {evt_x, evt_y, evt_pol, evt_ts};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Hold register is kept in wire order {b4..b0}, so a right shift walks every data bit LSB first.
    always_comb begin
        w_state_next    = r_state;
        w_baud_next     = r_baud + 1'b1;
        w_bit_idx_next  = r_bit_idx;
        w_byte_idx_next = r_byte_idx;
        w_pkt_next      = r_pkt;
        w_pop           = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_baud_next = '0;
                if (r_count != '0) begin
                    w_pop           = 1'b1;
                    w_pkt_next      = {w_head[7:0], w_head[15:8], w_head[23:16],
                                       w_head[31:24], w_head[39:32]};
                    w_byte_idx_next = '0;
                    w_state_next    = S_LOAD;
                end
            end
            S_LOAD: begin
                w_baud_next  = '0;
                w_state_next = S_START;
            end
            S_START: begin
                if (w_bit_end) begin
                    w_baud_next    = '0;
                    w_bit_idx_next = '0;
                    w_state_next   = S_DATA;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_baud_next = '0;
                    w_pkt_next  = r_pkt >> 1;
                    if (r_bit_idx == 4'd7) begin
                        w_state_next = S_STOP;
                    end else begin
                        w_bit_idx_next = r_bit_idx + 1'b1;
                    end
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    w_baud_next = '0;
                    if (r_byte_idx != 3'd4) begin
                        w_byte_idx_next = r_byte_idx + 1'b1;
                        w_state_next    = S_START;
                    end else if (PKT_GAP_BITS > 0) begin
                        w_bit_idx_next = '0;
                        w_state_next   = S_GAP;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            S_GAP: begin
                if (w_bit_end) begin
                    w_baud_next = '0;
                    if (r_bit_idx == GAP_LAST) begin
                        w_state_next = S_IDLE;
                    end else begin
                        w_bit_idx_next = r_bit_idx + 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        w_busy_next = (w_state_next == S_START) || (w_state_next == S_DATA) ||
                      (w_state_next == S_STOP)  || (w_state_next == S_GAP);
        case (w_state_next)
            S_START: w_tx_next = 1'b0;
            S_DATA:  w_tx_next = w_pkt_next[0];
            default: w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_baud     <= '0;
            r_bit_idx  <= '0;
            r_byte_idx <= '0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_baud     <= w_baud_next;
            r_bit_idx  <= w_bit_idx_next;
            r_byte_idx <= w_byte_idx_next;
            r_tx       <= w_tx_next;
            r_busy     <= w_busy_next;
        end
    end

    always_ff @(posedge clk) begin
        r_pkt <= w_pkt_next;
    end
endmodule
